// File: rtl/trap_pkg.sv
// trap_pkg: shared constants for the machine-mode trap controller.
//   - CSR addresses of the implemented M-mode registers
//   - synchronous exception and interrupt cause codes
//   - mstatus bit positions
//   - trap / mret sequencer state encoding
package trap_pkg;

   localparam logic [11:0] CsrMstatus  = 12'h300;
   localparam logic [11:0] CsrMie      = 12'h304;
   localparam logic [11:0] CsrMtvec    = 12'h305;
   localparam logic [11:0] CsrMscratch = 12'h340;
   localparam logic [11:0] CsrMepc     = 12'h341;
   localparam logic [11:0] CsrMcause   = 12'h342;
   localparam logic [11:0] CsrMtval    = 12'h343;
   localparam logic [11:0] CsrMip      = 12'h344;

   localparam logic [4:0] ExcIllegal    = 5'd2;
   localparam logic [4:0] ExcLoadFault  = 5'd5;
   localparam logic [4:0] ExcStoreFault = 5'd7;
   localparam logic [4:0] ExcEcallM     = 5'd11;

   localparam logic [4:0] IrqMsi = 5'd3;
   localparam logic [4:0] IrqMti = 5'd7;
   localparam logic [4:0] IrqMei = 5'd11;
   localparam int unsigned IrqLocalBase = 16;

   localparam int unsigned MstatusMie  = 3;
   localparam int unsigned MstatusMpie = 7;

   typedef enum logic [2:0] {
      StIdle,
      StTStat,
      StTEpc,
      StTCause,
      StTVec,
      StRet
   } trap_state_e;

endpackage

// File: rtl/trap_csr_file.sv
// trap_csr_file: M-mode CSR storage with WARL masking and reset values.
//   clk, rst          clock, synchronous active-low reset
//   addr, r_data      combinational read port (old value)
//   csr_we, wsc,      read-modify-write port on addr (01 write, 10 set, 11 clear)
//   operand
//   mip               live pending-interrupt vector, read-only view
//   stat_we           trap entry: MPIE <- MIE, MIE <- 0
//   ret_we            mret: MIE <- MPIE, MPIE <- 1
//   epc_we, epc_in    trap write of mepc
//   cause_we,         trap write of mcause and mtval
//   cause_in, tval_in
//   mstatus_mie, mie, mtvec, mepc   state views for the trap sequencer
module trap_csr_file
   import trap_pkg::*;
#(
   parameter int unsigned      XLEN        = 32,
   parameter int unsigned      NUM_LIRQ    = 4,
   parameter bit               VECTORED_EN = 1'b1,
   parameter logic [XLEN-1:0]  RESET_MTVEC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [11:0]     addr,
   output logic [XLEN-1:0] r_data,
   input  logic            csr_we,
   input  logic [1:0]      wsc,
   input  logic [XLEN-1:0] operand,
   input  logic [XLEN-1:0] mip,
   input  logic            stat_we,
   input  logic            ret_we,
   input  logic            epc_we,
   input  logic [XLEN-1:0] epc_in,
   input  logic            cause_we,
   input  logic [XLEN-1:0] cause_in,
   input  logic [XLEN-1:0] tval_in,
   output logic            mstatus_mie,
   output logic [XLEN-1:0] mie,
   output logic [XLEN-1:0] mtvec,
   output logic [XLEN-1:0] mepc
);

   // Only the standard M-mode lines and the implemented local lines are enableable.
   localparam logic [XLEN-1:0] LirqOnes = (XLEN'(1) << NUM_LIRQ) - XLEN'(1);
   localparam logic [XLEN-1:0] MieMask  = (LirqOnes << IrqLocalBase) | XLEN'(32'h888);

   logic            mst_mie_q, mst_mpie_q;
   logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
   logic [XLEN-1:0] mstatus_view, wdata;

   always_comb begin
      mstatus_view              = '0;
      mstatus_view[MstatusMie]  = mst_mie_q;
      mstatus_view[MstatusMpie] = mst_mpie_q;
      mstatus_view[12:11]       = 2'b11;  // MPP hardwired to M-mode
   end

   always_comb begin
      case (addr)
         CsrMstatus:  r_data = mstatus_view;
         CsrMie:      r_data = mie_q;
         CsrMtvec:    r_data = mtvec_q;
         CsrMscratch: r_data = mscratch_q;
         CsrMepc:     r_data = mepc_q;
         CsrMcause:   r_data = mcause_q;
         CsrMtval:    r_data = mtval_q;
         CsrMip:      r_data = mip;
         default:     r_data = '0;
      endcase
   end

   always_comb begin
      case (wsc)
         2'b01:   wdata = operand;
         2'b10:   wdata = r_data | operand;
         2'b11:   wdata = r_data & ~operand;
         default: wdata = r_data;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mst_mie_q  <= 1'b0;
         mst_mpie_q <= 1'b0;
         mie_q      <= '0;
         mtvec_q    <= RESET_MTVEC;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
      end else begin
         if (csr_we) begin
            case (addr)
               CsrMstatus: begin
                  mst_mie_q  <= wdata[MstatusMie];
                  mst_mpie_q <= wdata[MstatusMpie];
               end
               CsrMie:      mie_q      <= wdata & MieMask;
               CsrMtvec:    mtvec_q    <= {wdata[XLEN-1:2], 1'b0, VECTORED_EN & wdata[0]};
               CsrMscratch: mscratch_q <= wdata;
               CsrMepc:     mepc_q     <= {wdata[XLEN-1:2], 2'b00};
               CsrMcause:   mcause_q   <= wdata;
               CsrMtval:    mtval_q    <= wdata;
               default: ;
            endcase
         end
         if (stat_we) begin
            mst_mpie_q <= mst_mie_q;
            mst_mie_q  <= 1'b0;
         end
         if (ret_we) begin
            mst_mie_q  <= mst_mpie_q;
            mst_mpie_q <= 1'b1;
         end
         if (epc_we) mepc_q <= {epc_in[XLEN-1:2], 2'b00};
         if (cause_we) begin
            mcause_q <= cause_in;
            mtval_q  <= tval_in;
         end
      end
   end

   assign mstatus_mie = mst_mie_q;
   assign mie         = mie_q;
   assign mtvec       = mtvec_q;
   assign mepc        = mepc_q;

endmodule

// File: rtl/trap_unit.sv
// trap_unit: machine-mode trap controller.
//   clk, rst                         clock, synchronous active-low reset
//   csr_* inputs, csr_r_data_out     CSR instruction port (combinational read of old value)
//   irq_msi/mti/mei, irq_local       level interrupt lines
//   illegal_inst, ecall_m,           exception flags from WB
//   l_access_fault, s_access_fault
//   mret, tval_in, epc_cur, epc_next WB context for trap entry / return
//   PC_redirect, redirect_mux        fetch redirect (redirect_mux registered)
//   stall, reg_*_flush,              pipeline control
//   RegWrite_cancel
module trap_unit
   import trap_pkg::*;
#(
   parameter int unsigned      XLEN        = 32,
   parameter int unsigned      NUM_LIRQ    = 4,
   parameter bit               VECTORED_EN = 1'b1,
   parameter logic [XLEN-1:0]  RESET_MTVEC = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                csr_rw_in,
   input  logic [1:0]          csr_wsc_mode_in,
   input  logic                csr_w_imm_mux,
   input  logic [11:0]         csr_rw_addr_in,
   input  logic [XLEN-1:0]     csr_w_data_reg,
   input  logic [4:0]          csr_w_data_imm,
   output logic [XLEN-1:0]     csr_r_data_out,
   input  logic                irq_msi,
   input  logic                irq_mti,
   input  logic                irq_mei,
   input  logic [NUM_LIRQ-1:0] irq_local,
   input  logic                illegal_inst,
   input  logic                ecall_m,
   input  logic                l_access_fault,
   input  logic                s_access_fault,
   input  logic                mret,
   input  logic [XLEN-1:0]     tval_in,
   input  logic [XLEN-1:0]     epc_cur,
   input  logic [XLEN-1:0]     epc_next,
   output logic [XLEN-1:0]     PC_redirect,
   output logic                redirect_mux,
   output logic                stall,
   output logic                reg_FD_flush,
   output logic                reg_DE_flush,
   output logic                reg_EM_flush,
   output logic                reg_MW_flush,
   output logic                RegWrite_cancel
);

   trap_state_e     state_q, state_d;
   logic            redirect_q;
   logic [XLEN-1:0] mip, mie, mtvec, mepc, pending, operand;
   logic            mst_mie;
   logic            exc_any, irq_any, take_trap, take_mret, csr_we;
   logic [4:0]      exc_code, irq_code;
   logic            stat_we, ret_we, epc_we, cause_we;

   // Latched trap context
   logic [4:0]      code_q;
   logic            is_irq_q;
   logic [XLEN-1:0] epc_q, tval_q, cause_q;

   always_comb begin
      mip                              = '0;
      mip[IrqMsi]                      = irq_msi;
      mip[IrqMti]                      = irq_mti;
      mip[IrqMei]                      = irq_mei;
      mip[IrqLocalBase +: NUM_LIRQ]    = irq_local;
   end

   assign pending = mip & mie & {XLEN{mst_mie}};
   assign irq_any = |pending;
   assign exc_any = illegal_inst | ecall_m | l_access_fault | s_access_fault;
   assign operand = csr_w_imm_mux ? XLEN'(csr_w_data_imm) : csr_w_data_reg;

   always_comb begin
      exc_code = ExcStoreFault;
      if (l_access_fault) exc_code = ExcLoadFault;
      if (ecall_m)        exc_code = ExcEcallM;
      if (illegal_inst)   exc_code = ExcIllegal;
   end

   // Later assignments win: locals low..high, then mti, msi, mei.
   always_comb begin
      irq_code = '0;
      for (int i = 0; i < int'(NUM_LIRQ); i++) begin
         if (pending[IrqLocalBase + i]) irq_code = 5'(IrqLocalBase + i);
      end
      if (pending[IrqMti]) irq_code = IrqMti;
      if (pending[IrqMsi]) irq_code = IrqMsi;
      if (pending[IrqMei]) irq_code = IrqMei;
   end

   assign take_trap = rst && (state_q == StIdle) && (exc_any || irq_any);
   assign take_mret = rst && (state_q == StIdle) && !take_trap && mret;
   assign csr_we    = rst && (state_q == StIdle) && !take_trap && !take_mret && csr_rw_in &&
                      (csr_wsc_mode_in != 2'b00);

   always_comb begin
      state_d         = state_q;
      stat_we         = 1'b0;
      ret_we          = 1'b0;
      epc_we          = 1'b0;
      cause_we        = 1'b0;
      PC_redirect     = '0;
      reg_FD_flush    = 1'b0;
      reg_DE_flush    = 1'b0;
      reg_EM_flush    = 1'b0;
      reg_MW_flush    = 1'b0;
      RegWrite_cancel = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (take_trap) begin
               state_d         = StTStat;
               reg_FD_flush    = 1'b1;
               reg_DE_flush    = 1'b1;
               reg_EM_flush    = 1'b1;
               reg_MW_flush    = 1'b1;
               RegWrite_cancel = 1'b1;
            end else if (take_mret) begin
               state_d      = StRet;
               reg_FD_flush = 1'b1;
               reg_DE_flush = 1'b1;
               reg_EM_flush = 1'b1;
            end
         end
         StTStat: begin
            stat_we = 1'b1;
            state_d = StTEpc;
         end
         StTEpc: begin
            epc_we  = 1'b1;
            state_d = StTCause;
         end
         StTCause: begin
            cause_we = 1'b1;
            state_d  = StTVec;
         end
         StTVec: begin
            // Vector offset applies only to interrupts in vectored mode.
            PC_redirect = (mtvec & ~XLEN'(3)) +
                          ((is_irq_q && mtvec[0]) ? XLEN'({code_q, 2'b00}) : '0);
            state_d     = StIdle;
         end
         StRet: begin
            ret_we      = 1'b1;
            PC_redirect = mepc;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         redirect_q <= 1'b0;
         code_q     <= '0;
         is_irq_q   <= 1'b0;
         epc_q      <= '0;
         tval_q     <= '0;
         cause_q    <= '0;
      end else begin
         state_q    <= state_d;
         redirect_q <= (state_d == StTVec) || (state_d == StRet);
         if (take_trap) begin
            if (exc_any) begin
               code_q   <= exc_code;
               is_irq_q <= 1'b0;
               epc_q    <= epc_cur;
               tval_q   <= tval_in;
               cause_q  <= XLEN'(exc_code);
            end else begin
               code_q   <= irq_code;
               is_irq_q <= 1'b1;
               epc_q    <= epc_next;
               tval_q   <= '0;
               cause_q  <= XLEN'(irq_code) | (XLEN'(1) << (XLEN - 1));
            end
         end
      end
   end

   assign redirect_mux = redirect_q;
   assign stall        = (state_q != StIdle);

   trap_csr_file #(
      .XLEN        (XLEN),
      .NUM_LIRQ    (NUM_LIRQ),
      .VECTORED_EN (VECTORED_EN),
      .RESET_MTVEC (RESET_MTVEC)
   ) u_csr_file (
      .clk         (clk),
      .rst         (rst),
      .addr        (csr_rw_addr_in),
      .r_data      (csr_r_data_out),
      .csr_we      (csr_we),
      .wsc         (csr_wsc_mode_in),
      .operand     (operand),
      .mip         (mip),
      .stat_we     (stat_we),
      .ret_we      (ret_we),
      .epc_we      (epc_we),
      .epc_in      (epc_q),
      .cause_we    (cause_we),
      .cause_in    (cause_q),
      .tval_in     (tval_q),
      .mstatus_mie (mst_mie),
      .mie         (mie),
      .mtvec       (mtvec),
      .mepc        (mepc)
   );

endmodule

// File: doc/trap_unit.md
# trap_unit

Parametrised machine-mode trap controller; successor to the single-cycle exception unit in the core's MEM/WB boundary. Owns the M-mode CSR file, executes CSR instructions, prioritises synchronous exceptions against masked interrupts, and runs a multi-cycle trap-entry / `mret` sequencer. It stalls the pipeline while busy and redirects fetch through `mtvec` (direct or vectored) or `mepc`.

## Interface
- `XLEN`, 32: data and PC width.
- `NUM_LIRQ`, 4: local interrupt lines, 1..16. Line `i` uses cause `16+i`.
- `VECTORED_EN`, 1: allows `mtvec.MODE=01`.
- `RESET_MTVEC`, 32'h0000_0000: `mtvec` value after reset.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low. Asserted when 0; sampled on posedge `clk`.
- `csr_rw_in`  in  1  CSR instruction present in MEM.
- `csr_wsc_mode_in`  in  2  operation: 01 write, 10 set, 11 clear.
- `csr_w_imm_mux`  in  1  use zero-extended `csr_w_data_imm` as the operand.
- `csr_rw_addr_in`  in  12  CSR address.
- `csr_w_data_reg`  in  XLEN  rs1 operand.
- `csr_w_data_imm`  in  5  zimm operand.
- `csr_r_data_out`  out  XLEN  combinational read data, old value.
- `irq_msi`, `irq_mti`, `irq_mei`  in  1 each  level interrupts; causes 3, 7, 11.
- `irq_local`  in  NUM_LIRQ  level local interrupts.
- `illegal_inst`, `ecall_m`, `l_access_fault`, `s_access_fault`  in  1 each  exception flags from WB.
- `mret`  in  1  `mret` in WB.
- `tval_in`  in  XLEN  fault address or instruction bits.
- `epc_cur`  in  XLEN  PC of the WB instruction.
- `epc_next`  in  XLEN  oldest unflushed PC.
- `PC_redirect`  out  XLEN  redirect target.
- `redirect_mux`  out  1  selects `PC_redirect`; registered.
- `stall`  out  1  freezes all pipeline registers.
- `reg_FD_flush`, `reg_DE_flush`, `reg_EM_flush`, `reg_MW_flush`  out  1 each  flush signals.
- `RegWrite_cancel`  out  1  kills the WB register write.

## Operation
- **CSRs:** `mstatus` 300, `mie` 304, `mtvec` 305, `mscratch` 340, `mepc` 341, `mcause` 342, `mtval` 343, `mip` 344.
  - `mip` is read-only and reflects the live IRQ inputs.
  - Unimplemented addresses read 0; writes to them are dropped.
  - `mstatus`: only MIE[3], MPIE[7] and MPP[12:11] are writable. MPP always reads 11.
  - `mepc[1:0]` is forced to 0.
  - `mtvec[1]` is forced to 0. `mtvec[0]` is forced to 0 when `VECTORED_EN=0`.
- **CSR instruction:** accepted in IDLE only when no trap or `mret` is taken in the same cycle. The write lands on the next posedge.
- **Exception priority:** `illegal_inst` (cause 2) > `ecall_m` (11) > `l_access_fault` (5) > `s_access_fault` (7).
- **Interrupts:**
  - Pending set = `mip & mie`, gated by `mstatus.MIE`.
  - Priority: mei > msi > mti > `local[NUM_LIRQ-1]` … `local[0]`.
  - Taken only when no exception is present. `mcause[XLEN-1]` = 1.
- **EPC source:** exceptions save `epc_cur`; interrupts save `epc_next`.
- **`mtval`:** exceptions save `tval_in`; interrupts save 0.
- **FSM:** IDLE → T_STAT → T_EPC → T_CAUSE → T_VEC → IDLE; IDLE → RET → IDLE.
  - **IDLE, trap detected:**
    - Latch cause, epc and tval.
    - Assert all four flushes and `RegWrite_cancel` combinationally.
    - Go to T_STAT.
  - **T_STAT:** MPIE ← MIE, MIE ← 0.
  - **T_EPC:** write `mepc`.
  - **T_CAUSE:** write `mcause` and `mtval`.
  - **T_VEC:**
    - `PC_redirect` = `mtvec.BASE`, plus `4*code` when vectored and the trap is an interrupt.
    - Go to IDLE.
  - **IDLE, `mret`:** flush FD, DE and EM. MW is not flushed. Go to RET.
  - **RET:**
    - MIE ← MPIE, MPIE ← 1.
    - `PC_redirect` = `mepc`.
- **Inputs while busy:** `stall` = 1 in every non-IDLE state. Exception, IRQ, `mret` and CSR inputs are ignored outside IDLE.
- **Simultaneous events in IDLE:** exception > interrupt > `mret` > CSR instruction.

## Timing
- **Trap entry:** trap seen at cycle t. `redirect_mux` = 1 during t+4 only. Fetch resumes at t+5.
- **`mret`:** seen at t. `redirect_mux` = 1 during t+1.
- **Redirect valid:** `PC_redirect` is valid whenever `redirect_mux` = 1.
- **CSR read:** zero latency.
- **CSR write:** visible to reads from t+1.
- **Reset (`rst` = 0 at a posedge):**
  - FSM returns to IDLE, including mid-sequence.
  - `mstatus` = 0x0000_1800, `mtvec` = `RESET_MTVEC`, all other CSRs = 0.
  - `redirect_mux` = 0 and `stall` = 0.
  - Flushes and `RegWrite_cancel` are held at 0 while `rst` = 0.
- **Partial trap at reset:** a trap interrupted by reset leaves no partial CSR update visible after reset.

## Structure
- Package `trap_pkg`: CSR address constants, exception and interrupt cause codes, FSM state enum, `mstatus` bit indices.
- Sub-module `trap_csr_file`:
  - One combinational read port and one read-modify-write port that applies `wsc`.
  - Extra dedicated write strobes for trap and `mret` updates.
  - Reset values and WARL masking live here.
- The FSM, priority encoders and vector arithmetic stay in `trap_unit`.

## Test plan
- **CSR RMW:** `mtvec`=0x100 written, `mie` 0x888 set, bit 3 cleared → reads back 0x100 and 0x880. Write to 0x7C0 reads 0.
- **`ecall_m` entry:** `ecall_m` with `epc_cur`=0x40 → `mepc`=0x40, `mcause`=11, MIE=0, MPIE=old MIE. Redirect to 0x100 exactly 4 cycles later; `stall` high for cycles t+1..t+4.
- **Vectored interrupt:** `mtvec`=0x201, MIE=1, `mie.MEIE`=1, `irq_mei`=1 with `epc_next`=0x88 → `mcause`=0x8000_000B, `mepc`=0x88, target 0x22C.
- **Priority and masking:**
  - `illegal_inst`, `s_access_fault` and `irq_mti` raised together → `mcause`=2.
  - With MIE=0, `irq_mti` alone → no trap.
- **`mret`:** `mret` with `mepc`=0x44, MPIE=1 → redirect to 0x44 at t+1, MIE=1, `reg_MW_flush`=0.
- **Reset mid-operation:** `rst`=0 during T_EPC → IDLE, `mepc`=0, `mstatus`=0x1800, no redirect pulse.
